// File: rtl/ide_pio_device.sv
`default_nettype none
// ============================================================================
// Module   : ide_pio_device
// Function : ATA task-file PIO device; moves whole sectors between a local
//            buffer and a streaming backing store (multi-sector READ/WRITE).
// Revision : 1.0
// ============================================================================
module ide_pio_device #(
    parameter int          SECTOR_BYTES = 512,
    parameter logic [27:0] MAX_LBA      = 28'h00FFFFF
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        ce_n,
    input  logic        oe_n,
    input  logic        we_n,
    input  logic [2:0]  address,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        intrq,
    output logic        st_cmd_valid,
    input  logic        st_cmd_ready,
    output logic        st_cmd_write,
    output logic [27:0] st_cmd_lba,
    input  logic        st_rvalid,
    input  logic [7:0]  st_rdata,
    output logic        st_wvalid,
    input  logic        st_wready,
    output logic [7:0]  st_wdata,
    input  logic        st_done
);
    localparam int                 c_PTR_W    = $clog2(SECTOR_BYTES);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(SECTOR_BYTES - 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_FETCH_REQ  = 3'd1;
    localparam logic [2:0] c_FETCH_DATA = 3'd2;
    localparam logic [2:0] c_DRQ_RD     = 3'd3;
    localparam logic [2:0] c_DRQ_WR     = 3'd4;
    localparam logic [2:0] c_STORE_REQ  = 3'd5;
    localparam logic [2:0] c_STORE_DATA = 3'd6;
    localparam logic [2:0] c_STORE_WAIT = 3'd7;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_PTR_W-1:0] r_ptr;
    logic [7:0]         r_buf [0:SECTOR_BYTES-1];
    logic [7:0]         r_error, r_count, r_lba_lo, r_lba_mid, r_lba_hi, r_device;
    logic               r_err, r_intrq;
    logic               r_wr_prev, r_rd_prev;
    logic [2:0]         r_rd_addr;

    logic        w_wr_strobe, w_rd_strobe, w_wr_event, w_rd_event, w_host_ok;
    logic        w_busy, w_drq, w_ptr_last, w_more;
    logic [7:0]  w_status, w_buf_word, w_buf_wdata;
    logic [27:0] w_lba, w_lba_next;
    logic        w_buf_we, w_ptr_inc, w_sector_done, w_set_intrq;
    logic        w_cmd_accept, w_err_idnf, w_err_abrt;

    assign w_wr_strobe = !ce_n && !we_n;
    assign w_rd_strobe = !ce_n && !oe_n;
    assign w_wr_event  = w_wr_strobe && !r_wr_prev;
    // A read completes when the strobe is released, so the pointer advances after the byte was seen.
    assign w_rd_event  = r_rd_prev && oe_n;

    assign w_busy = (r_state == c_FETCH_REQ) || (r_state == c_FETCH_DATA) ||
                    (r_state == c_STORE_REQ) || (r_state == c_STORE_DATA) ||
                    (r_state == c_STORE_WAIT);
    assign w_drq  = (r_state == c_DRQ_RD) || (r_state == c_DRQ_WR);
    assign w_host_ok = w_wr_event && !w_busy && !w_drq;

    assign w_status   = {w_busy, 1'b1, 2'b00, w_drq, 2'b00, r_err};
    assign w_lba      = {r_device[3:0], r_lba_hi, r_lba_mid, r_lba_lo};
    assign w_lba_next = w_lba + 28'd1;
    assign w_ptr_last = (r_ptr == c_PTR_LAST);
    // Count 0 encodes 256 sectors, so only a count of 1 is the final sector.
    assign w_more     = (r_count != 8'd1);
    assign w_buf_word = r_buf[r_ptr];

    always_comb begin
        w_state_next  = r_state;
        w_buf_we      = 1'b0;
        w_buf_wdata   = data_in;
        w_ptr_inc     = 1'b0;
        w_sector_done = 1'b0;
        w_set_intrq   = 1'b0;
        w_cmd_accept  = 1'b0;
        w_err_idnf    = 1'b0;
        w_err_abrt    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_host_ok && address == 3'd7) begin
                    w_cmd_accept = 1'b1;
                    case (data_in)
                        8'h20, 8'h30: begin
                            if (w_lba > MAX_LBA)
                                w_err_idnf = 1'b1;
                            else
                                w_state_next = (data_in == 8'h20) ? c_FETCH_REQ : c_DRQ_WR;
                        end
                        8'hE7:   w_set_intrq = 1'b1;
                        default: w_err_abrt  = 1'b1;
                    endcase
                end
            end
            c_FETCH_REQ: begin
                if (st_cmd_ready)
                    w_state_next = c_FETCH_DATA;
            end
            c_FETCH_DATA: begin
                if (st_rvalid) begin
                    w_buf_we    = 1'b1;
                    w_buf_wdata = st_rdata;
                    w_ptr_inc   = 1'b1;
                    if (w_ptr_last) begin
                        w_state_next = c_DRQ_RD;
                        w_set_intrq  = 1'b1;
                    end
                end
            end
            c_DRQ_RD: begin
                if (w_rd_event && r_rd_addr == 3'd0) begin
                    w_ptr_inc = 1'b1;
                    if (w_ptr_last) begin
                        w_sector_done = 1'b1;
                        if (!w_more)
                            w_state_next = c_IDLE;
                        else if (w_lba_next > MAX_LBA)
                            w_err_idnf = 1'b1;
                        else
                            w_state_next = c_FETCH_REQ;
                    end
                end
            end
            c_DRQ_WR: begin
                if (w_wr_event && address == 3'd0) begin
                    w_buf_we  = 1'b1;
                    w_ptr_inc = 1'b1;
                    if (w_ptr_last)
                        w_state_next = c_STORE_REQ;
                end
            end
            c_STORE_REQ: begin
                if (st_cmd_ready)
                    w_state_next = c_STORE_DATA;
            end
            c_STORE_DATA: begin
                if (st_wready) begin
                    w_ptr_inc = 1'b1;
                    if (w_ptr_last)
                        w_state_next = c_STORE_WAIT;
                end
            end
            c_STORE_WAIT: begin
                if (st_done) begin
                    w_sector_done = 1'b1;
                    w_set_intrq   = 1'b1;
                    if (!w_more)
                        w_state_next = c_IDLE;
                    else if (w_lba_next > MAX_LBA)
                        w_err_idnf = 1'b1;
                    else
                        w_state_next = c_DRQ_WR;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
        if (w_err_idnf || w_err_abrt) begin
            w_set_intrq  = 1'b1;
            w_state_next = c_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state   <= c_IDLE;
            r_ptr     <= '0;
            r_error   <= 8'h01;
            r_count   <= 8'h01;
            r_lba_lo  <= 8'h00;
            r_lba_mid <= 8'h00;
            r_lba_hi  <= 8'h00;
            r_device  <= 8'h00;
            r_err     <= 1'b0;
            r_intrq   <= 1'b0;
            r_wr_prev <= 1'b0;
            r_rd_prev <= 1'b0;
            r_rd_addr <= 3'd0;
        end else begin
            r_state   <= w_state_next;
            r_wr_prev <= w_wr_strobe;
            r_rd_prev <= w_rd_strobe;
            if (w_rd_strobe)
                r_rd_addr <= address;
            if (w_ptr_inc)
                r_ptr <= r_ptr + c_PTR_W'(1);
            if (w_host_ok) begin
                case (address)
                    3'd2:    r_count   <= data_in;
                    3'd3:    r_lba_lo  <= data_in;
                    3'd4:    r_lba_mid <= data_in;
                    3'd5:    r_lba_hi  <= data_in;
                    3'd6:    r_device  <= data_in;
                    default: ;
                endcase
            end
            if (w_sector_done) begin
                {r_device[3:0], r_lba_hi, r_lba_mid, r_lba_lo} <= w_lba_next;
                r_count <= r_count - 8'd1;
            end
            if (w_cmd_accept) begin
                r_err   <= 1'b0;
                r_error <= 8'h00;
            end
            if (w_err_idnf) begin
                r_err   <= 1'b1;
                r_error <= 8'h10;
            end
            if (w_err_abrt) begin
                r_err   <= 1'b1;
                r_error <= 8'h04;
            end
            if (w_set_intrq)
                r_intrq <= 1'b1;
            else if (w_cmd_accept || (w_rd_event && r_rd_addr == 3'd7))
                r_intrq <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we && !arst)
            r_buf[r_ptr] <= w_buf_wdata;
    end

    always_comb begin
        case (address)
            3'd0:    data_out = w_drq ? w_buf_word : 8'hFF;
            3'd1:    data_out = r_error;
            3'd2:    data_out = r_count;
            3'd3:    data_out = r_lba_lo;
            3'd4:    data_out = r_lba_mid;
            3'd5:    data_out = r_lba_hi;
            3'd6:    data_out = r_device;
            default: data_out = w_status;
        endcase
    end

    assign intrq        = r_intrq;
    assign st_cmd_valid = (r_state == c_FETCH_REQ) || (r_state == c_STORE_REQ);
    assign st_cmd_write = (r_state == c_STORE_REQ);
    assign st_cmd_lba   = w_lba;
    assign st_wvalid    = (r_state == c_STORE_DATA);
    assign st_wdata     = w_buf_word;

endmodule
`default_nettype wire

// File: tb/tb_ide_pio_device.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ide_pio_device
// Function : Self-checking bench; a disk image array acts as backing store.
// Revision : 1.0
// ============================================================================
module tb_ide_pio_device;
    localparam int          SB   = 512;
    localparam logic [27:0] MAXL = 28'd100;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        intrq;
    logic        st_cmd_valid, st_cmd_write;
    logic        st_cmd_ready = 1'b0;
    logic [27:0] st_cmd_lba;
    logic        st_rvalid = 1'b0;
    logic [7:0]  st_rdata = 8'h00;
    logic        st_wvalid;
    logic        st_wready = 1'b0;
    logic [7:0]  st_wdata;
    logic        st_done = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] disk [0:127][0:SB-1];
    logic [7:0] rbuf [0:SB-1];
    logic [7:0] wcap [0:SB-1];
    logic [7:0] wexp [0:SB-1];

    always #5 clk = ~clk;

    ide_pio_device #(.SECTOR_BYTES(SB), .MAX_LBA(MAXL)) dut (
        .clk(clk), .arst(arst), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
        .address(address), .data_in(data_in), .data_out(data_out), .intrq(intrq),
        .st_cmd_valid(st_cmd_valid), .st_cmd_ready(st_cmd_ready),
        .st_cmd_write(st_cmd_write), .st_cmd_lba(st_cmd_lba),
        .st_rvalid(st_rvalid), .st_rdata(st_rdata),
        .st_wvalid(st_wvalid), .st_wready(st_wready), .st_wdata(st_wdata),
        .st_done(st_done)
    );

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk); address = a; data_in = d; ce_n = 1'b0; we_n = 1'b0;
        @(negedge clk); ce_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk); address = a; ce_n = 1'b0; oe_n = 1'b0;
        @(negedge clk); d = data_out; ce_n = 1'b1; oe_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        address = a; #1; d = data_out;
    endtask

    task automatic set_taskfile(input logic [7:0] cnt, input logic [27:0] lba);
        host_write(3'd2, cnt);
        host_write(3'd3, lba[7:0]);
        host_write(3'd4, lba[15:8]);
        host_write(3'd5, lba[23:16]);
        host_write(3'd6, {4'hE, lba[27:24]});
    endtask

    task automatic serve_cmd(output bit ok, output logic [27:0] lba, output logic wr);
        ok = 1'b0; lba = '0; wr = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (st_cmd_valid) begin ok = 1'b1; lba = st_cmd_lba; wr = st_cmd_write; end
        end
        if (ok) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            st_cmd_ready = 1'b1;
            @(negedge clk);
            st_cmd_ready = 1'b0;
        end
    endtask

    task automatic feed_sector(input int lba);
        for (int i = 0; i < SB; i++) begin
            if ($urandom_range(0, 3) == 0) begin st_rvalid = 1'b0; @(negedge clk); end
            st_rvalid = 1'b1; st_rdata = disk[lba][i];
            @(negedge clk);
        end
        st_rvalid = 1'b0;
    endtask

    task automatic read_sector();
        logic [7:0] d;
        for (int i = 0; i < SB; i++) begin host_read(3'd0, d); rbuf[i] = d; end
    endtask

    task automatic collect_write(output int n);
        bit tog;
        tog = 1'b0; n = 0;
        for (int c = 0; c < 4 * SB && n < SB; c++) begin
            @(negedge clk); tog = ~tog; st_wready = tog;
            if (st_wvalid && tog) begin wcap[n] = st_wdata; n++; end
        end
        @(negedge clk); st_wready = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        arst = 1'b1; repeat (3) @(negedge clk); arst = 1'b0;
        peek(3'd7, d); checks++; if (d !== 8'h40) begin failures++; $display("FAIL rst_status got %h want 40", d); end
        peek(3'd1, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL rst_error got %h want 01", d); end
        peek(3'd2, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL rst_count got %h want 01", d); end
        peek(3'd3, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_lba got %h want 00", d); end
        peek(3'd0, d); checks++; if (d !== 8'hFF) begin failures++; $display("FAIL rst_data got %h want FF", d); end
        checks++; if (intrq !== 1'b0) begin failures++; $display("FAIL rst_intrq got %b want 0", intrq); end
        checks++; if (st_cmd_valid !== 1'b0 || st_wvalid !== 1'b0) begin
            failures++; $display("FAIL rst_stream got cmd=%b wv=%b want 0 0", st_cmd_valid, st_wvalid); end
    endtask

    task automatic test_read_single();
        logic [7:0] d; bit ok; logic [27:0] lba; logic wr; int bad;
        for (int i = 0; i < SB; i++) disk[5][i] = 8'(i) ^ 8'h5A;
        set_taskfile(8'd1, 28'd5);
        host_write(3'd7, 8'h20);
        peek(3'd7, d); checks++; if ((d & 8'h88) !== 8'h80) begin failures++; $display("FAIL rd1_bsy status got %h want BSY only", d); end
        checks++; if (st_cmd_valid !== 1'b1) begin failures++; $display("FAIL rd1_cmd_valid got %b want 1", st_cmd_valid); end
        serve_cmd(ok, lba, wr);
        checks++; if (!ok || lba !== 28'd5 || wr !== 1'b0) begin
            failures++; $display("FAIL rd1_cmd got ok=%0d lba=%0d wr=%b want 1 5 0", ok, lba, wr); end
        feed_sector(5);
        peek(3'd7, d); checks++; if (d !== 8'h48) begin failures++; $display("FAIL rd1_drq status got %h want 48", d); end
        checks++; if (intrq !== 1'b1) begin failures++; $display("FAIL rd1_intrq got %b want 1", intrq); end
        host_read(3'd7, d);
        checks++; if (intrq !== 1'b0) begin failures++; $display("FAIL rd1_intrq_clr got %b want 0", intrq); end
        read_sector();
        bad = 0; for (int i = 0; i < SB; i++) if (rbuf[i] !== disk[5][i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rd1_data bad_bytes got %0d want 0", bad); end
        peek(3'd7, d); checks++; if (d !== 8'h40) begin failures++; $display("FAIL rd1_final status got %h want 40", d); end
        peek(3'd3, d); checks++; if (d !== 8'h06) begin failures++; $display("FAIL rd1_lba got %h want 06", d); end
        peek(3'd2, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL rd1_count got %h want 00", d); end
    endtask

    task automatic test_read_multi();
        logic [7:0] d; bit ok; logic [27:0] lba; logic wr; int bad, irqs;
        for (int s = 10; s < 13; s++) for (int i = 0; i < SB; i++) disk[s][i] = 8'($urandom);
        set_taskfile(8'd3, 28'd10);
        host_write(3'd7, 8'h20);
        irqs = 0;
        for (int s = 0; s < 3; s++) begin
            serve_cmd(ok, lba, wr);
            checks++; if (!ok || lba !== 28'(10 + s) || wr !== 1'b0) begin
                failures++; $display("FAIL rdm_cmd%0d got ok=%0d lba=%0d wr=%b want 1 %0d 0", s, ok, lba, wr, 10 + s); end
            feed_sector(10 + s);
            if (intrq === 1'b1) irqs++;
            host_read(3'd7, d);
            checks++; if (d !== 8'h48) begin failures++; $display("FAIL rdm_status%0d got %h want 48", s, d); end
            read_sector();
            bad = 0; for (int i = 0; i < SB; i++) if (rbuf[i] !== disk[10 + s][i]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rdm_data%0d bad_bytes got %0d want 0", s, bad); end
        end
        checks++; if (irqs != 3) begin failures++; $display("FAIL rdm_irqs got %0d want 3", irqs); end
        peek(3'd3, d); checks++; if (d !== 8'd13) begin failures++; $display("FAIL rdm_lba got %0d want 13", d); end
        peek(3'd2, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL rdm_count got %h want 00", d); end
        peek(3'd7, d); checks++; if (d !== 8'h40) begin failures++; $display("FAIL rdm_final got %h want 40", d); end
    endtask

    task automatic test_write_multi();
        logic [7:0] d; bit ok; logic [27:0] lba; logic wr; int bad, n, start;
        start = 40 + $urandom_range(0, 20);
        set_taskfile(8'd2, 28'(start));
        host_write(3'd7, 8'h30);
        peek(3'd7, d); checks++; if (d !== 8'h48) begin failures++; $display("FAIL wr_drq got %h want 48", d); end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < SB; i++) wexp[i] = 8'($urandom);
            for (int i = 0; i < SB; i++) host_write(3'd0, wexp[i]);
            peek(3'd7, d); checks++; if ((d & 8'h88) !== 8'h80) begin failures++; $display("FAIL wr_bsy%0d got %h want BSY only", s, d); end
            serve_cmd(ok, lba, wr);
            checks++; if (!ok || lba !== 28'(start + s) || wr !== 1'b1) begin
                failures++; $display("FAIL wr_cmd%0d got ok=%0d lba=%0d wr=%b want 1 %0d 1", s, ok, lba, wr, start + s); end
            collect_write(n);
            checks++; if (n != SB || st_wvalid !== 1'b0) begin
                failures++; $display("FAIL wr_len%0d got %0d wv=%b want %0d 0", s, n, st_wvalid, SB); end
            bad = 0; for (int i = 0; i < SB; i++) if (wcap[i] !== wexp[i]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL wr_data%0d bad_bytes got %0d want 0", s, bad); end
            repeat (20) @(negedge clk);
            checks++; if (intrq !== 1'b0) begin failures++; $display("FAIL wr_early_irq%0d got %b want 0", s, intrq); end
            st_done = 1'b1; @(negedge clk); st_done = 1'b0;
            checks++; if (intrq !== 1'b1) begin failures++; $display("FAIL wr_irq%0d got %b want 1", s, intrq); end
            peek(3'd7, d); checks++; if (d !== ((s == 0) ? 8'h48 : 8'h40)) begin
                failures++; $display("FAIL wr_status%0d got %h want %h", s, d, (s == 0) ? 8'h48 : 8'h40); end
            host_read(3'd7, d);
        end
        peek(3'd3, d); checks++; if (d !== 8'(start + 2)) begin failures++; $display("FAIL wr_lba got %0d want %0d", d, start + 2); end
        peek(3'd2, d); checks++; if (d !== 8'h00) begin failures++; $display("FAIL wr_count got %h want 00", d); end
    endtask

    task automatic test_range_error();
        logic [7:0] d; bit ok, seen; logic [27:0] lba; logic wr; int bad;
        for (int i = 0; i < SB; i++) disk[100][i] = 8'($urandom);
        set_taskfile(8'd2, 28'd100);
        host_write(3'd7, 8'h20);
        serve_cmd(ok, lba, wr);
        checks++; if (!ok || lba !== 28'd100) begin failures++; $display("FAIL rng_cmd got ok=%0d lba=%0d want 1 100", ok, lba); end
        feed_sector(100);
        host_read(3'd7, d);
        read_sector();
        bad = 0; for (int i = 0; i < SB; i++) if (rbuf[i] !== disk[100][i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rng_data bad_bytes got %0d want 0", bad); end
        peek(3'd7, d); checks++; if (d !== 8'h41) begin failures++; $display("FAIL rng_status got %h want 41", d); end
        peek(3'd1, d); checks++; if (d !== 8'h10) begin failures++; $display("FAIL rng_error got %h want 10", d); end
        checks++; if (intrq !== 1'b1) begin failures++; $display("FAIL rng_irq got %b want 1", intrq); end
        peek(3'd3, d); checks++; if (d !== 8'd101) begin failures++; $display("FAIL rng_lba got %0d want 101", d); end
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (st_cmd_valid) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL rng_nocmd got cmd=1 want 0"); end
        set_taskfile(8'd1, 28'd101);
        host_write(3'd7, 8'h20);
        peek(3'd7, d); checks++; if (d !== 8'h41 || st_cmd_valid !== 1'b0) begin
            failures++; $display("FAIL rng_direct got status=%h cmd=%b want 41 0", d, st_cmd_valid); end
        host_read(3'd7, d);
    endtask

    task automatic test_abort_flush();
        logic [7:0] d;
        host_write(3'd7, 8'h91);
        peek(3'd7, d); checks++; if (d !== 8'h41) begin failures++; $display("FAIL abrt_status got %h want 41", d); end
        peek(3'd1, d); checks++; if (d !== 8'h04) begin failures++; $display("FAIL abrt_error got %h want 04", d); end
        checks++; if (intrq !== 1'b1) begin failures++; $display("FAIL abrt_irq got %b want 1", intrq); end
        host_read(3'd7, d);
        checks++; if (intrq !== 1'b0) begin failures++; $display("FAIL abrt_irq_clr got %b want 0", intrq); end
        host_write(3'd7, 8'hE7);
        peek(3'd7, d); checks++; if (d !== 8'h40 || intrq !== 1'b1) begin
            failures++; $display("FAIL flush got status=%h irq=%b want 40 1", d, intrq); end
    endtask

    task automatic test_arst();
        logic [7:0] d; bit ok; logic [27:0] lba; logic wr; int bad;
        for (int i = 0; i < SB; i++) disk[7][i] = 8'($urandom);
        set_taskfile(8'd1, 28'd7);
        host_write(3'd7, 8'h20);
        host_write(3'd2, 8'h77);
        peek(3'd2, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL busy_wr_ignored got %h want 01", d); end
        serve_cmd(ok, lba, wr);
        for (int i = 0; i < 100; i++) begin st_rvalid = 1'b1; st_rdata = 8'($urandom); @(negedge clk); end
        arst = 1'b1; @(negedge clk); arst = 1'b0;
        checks++; if (st_cmd_valid !== 1'b0 || intrq !== 1'b0) begin
            failures++; $display("FAIL arst_out got cmd=%b irq=%b want 0 0", st_cmd_valid, intrq); end
        repeat (8) @(negedge clk);
        st_rvalid = 1'b0; st_done = 1'b1; @(negedge clk); st_done = 1'b0;
        peek(3'd7, d); checks++; if (d !== 8'h40) begin failures++; $display("FAIL arst_status got %h want 40", d); end
        peek(3'd1, d); checks++; if (d !== 8'h01) begin failures++; $display("FAIL arst_error got %h want 01", d); end
        peek(3'd0, d); checks++; if (d !== 8'hFF) begin failures++; $display("FAIL arst_data got %h want FF", d); end
        set_taskfile(8'd1, 28'd7);
        host_write(3'd7, 8'h20);
        serve_cmd(ok, lba, wr);
        checks++; if (!ok || lba !== 28'd7) begin failures++; $display("FAIL arst_recmd got ok=%0d lba=%0d want 1 7", ok, lba); end
        feed_sector(7);
        host_read(3'd7, d);
        read_sector();
        bad = 0; for (int i = 0; i < SB; i++) if (rbuf[i] !== disk[7][i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL arst_reread bad_bytes got %0d want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_read_single();
        test_read_multi();
        test_write_multi();
        test_range_error();
        test_abort_flush();
        test_arst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ide_pio_device.md
# ide_pio_device

Parametrised ATA/IDE PIO device emulator: presents the eight-register ATA task file on the CPU-side IDE bus (`ce_n`/`oe_n`/`we_n`/`address`/`data_in`/`data_out`) and moves whole sectors between a local sector buffer and a streaming backing-store port. It generalises the single-command IDE block in three ways: configurable sector size and capacity, multi-sector READ and WRITE, and an interrupt line. It sits between the CPU bus decoder and the storage controller (SRAM or SD bridge).

## Interface
- `SECTOR_BYTES`, 512: sector and buffer size; power of two, ≥16.
- `MAX_LBA`, 28'h00FFFFF: highest valid LBA.
- `clk` in 1: single clock; all logic on rising edge.
- `arst` in 1: reset, synchronous, active-high.
- `ce_n`, `oe_n`, `we_n` in 1 each: chip enable, read strobe, write strobe (active low).
- `address` in 3: task-file register select.
- `data_in` in 8: write data. `data_out` out 8: read data.
- `intrq` out 1: device interrupt, level.
- `st_cmd_valid` out 1, `st_cmd_ready` in 1, `st_cmd_write` out 1, `st_cmd_lba` out 28: sector command handshake.
- `st_rvalid` in 1, `st_rdata` in 8: read stream, exactly SECTOR_BYTES beats, no backpressure.
- `st_wvalid` out 1, `st_wready` in 1, `st_wdata` out 8: write stream.
- `st_done` in 1: one-cycle pulse when a written sector is committed.

## Operation
- Registers (read/write): 0 data; 1 error/features (features ignored); 2 sector count; 3/4/5 LBA[7:0]/[15:8]/[23:16]; 6 device (bits 3:0 = LBA[27:24]); 7 status/command.
- Status: bit7 BSY, bit6 DRDY, bit3 DRQ, bit0 ERR. Error: bit4 IDNF, bit2 ABRT.
- Write event: first cycle with `ce_n`=0 and `we_n`=0 after a cycle without it. Read event ends on the first cycle `oe_n` returns high after a cycle with `ce_n`=0 and `oe_n`=0.
- `data_out` is the combinational mux of the selected register; data register reads return `buffer[ptr]` while DRQ=1, else 0xFF.
- Writes to registers 1–7 are ignored while BSY=1 or DRQ=1. Data writes count only while DRQ=1 in a write command.
- Sector count 0 means 256. After each completed sector: LBA += 1, count -= 1, both visible in the task file.
- Commands:
  - 0x20 READ SECTORS.
  - 0x30 WRITE SECTORS.
  - 0xE7 FLUSH CACHE: completes immediately with `intrq`.
  - Anything else: ERR=1, ABRT, `intrq`.
- FSM states: IDLE, FETCH_REQ, FETCH_DATA, DRQ_RD, DRQ_WR, STORE_REQ, STORE_DATA, STORE_WAIT.
  - READ: IDLE → FETCH_REQ (`st_cmd_valid`, write=0, held until ready) → FETCH_DATA (buffer fills in beat order) → DRQ_RD. The read event of the last byte goes to FETCH_REQ if sectors remain, else IDLE.
  - WRITE: IDLE → DRQ_WR. Last byte written → STORE_REQ → STORE_DATA (bytes in order on `st_wvalid`/`st_wready`) → STORE_WAIT. `st_done` goes to DRQ_WR if sectors remain, else IDLE.
- Range check before each sector: current LBA > MAX_LBA → ERR, IDNF, `intrq`, go to IDLE; no storage command is issued.
- `intrq` sets on entry to DRQ_RD, on each `st_done`, on error, and on FLUSH. It clears on a status read event or a command write.
- `st_rvalid` outside FETCH_DATA and `st_done` outside STORE_WAIT are ignored.

## Timing
- Reset values:
  - status 0x40, error 0x01, count 0x01, LBA/device 0x00.
  - `intrq`, `st_cmd_valid`, `st_wvalid` all 0; state IDLE; ptr 0.
- Command write at cycle N: BSY (or DRQ for WRITE) is visible at N+1, and `st_cmd_valid` asserts at N+1.
- The last `st_rvalid` beat at cycle M gives BSY=0, DRQ=1, `intrq`=1 at M+1.
- The last host data byte at cycle K gives BSY=1, DRQ=0 at K+1.
- `st_done` at cycle D gives `intrq`=1 at D+1, together with DRQ=1 or status 0x40.
- Errors are visible one cycle after the command write or the failing range check.
- Buffer pointer wraps to 0 after SECTOR_BYTES accesses.
- `arst` mid-operation: all outputs return to reset values on the next edge, and any partial stream is abandoned.

## Test plan
- Reset → status 0x40, error 0x01, count 0x01, `intrq`=0, `st_cmd_valid`=0.
- Count=1, LBA=5, cmd 0x20:
  - `st_cmd_lba`=5, `st_cmd_write`=0.
  - Feed bytes i^0x5A → status 0x48 and `intrq`=1; status read clears `intrq`.
  - 512 data reads match i^0x5A; final status 0x40.
- Count=3, LBA=10, READ → commands for LBA 10, 11, 12; three interrupts; afterwards LBA regs=13, count=0.
- Count=2, WRITE, `st_wready` toggling every cycle, `st_done` 20 cycles late → bytes arrive in order; `intrq` after each `st_done`; final status 0x40.
- MAX_LBA=100, LBA=100, count=2, READ → first sector succeeds; second sector gives status 0x41, error 0x10, `intrq`=1, no second `st_cmd_valid`.
- Cmd 0x91 → status 0x41, error 0x04 next cycle. `arst` during FETCH_DATA → `st_cmd_valid`=0, status 0x40, stray `st_rvalid` ignored.
